saida_pwm_defuzzy: RTL and testbench
====================================

SAIDA_PWM_DEFUZZY -- requirements
Module: saida_pwm_defuzzy

Interface
REQ-001 Parameter PASSO_MAX, default 16: maximum duty change, in LSBs, per PWM period (slew limit); legal range 1..255.
REQ-002 Parameter PRESCALER, default 4: clk_0 cycles per PWM count step; legal range 1..256.
REQ-003 clk_0  input  1  single block clock; all state updates on its rising edge.
REQ-004 Srst  input  1  reset; synchronous and active-low.
REQ-005 Amostra_en  input  1  one-cycle strobe; Saida_defuzzy is valid in this cycle (driven by the controller's end-of-rule-sweep event).
REQ-006 Saida_defuzzy  input  8  crisp defuzzifier result, unsigned 0..255.
REQ-007 PWM_out  output  1  registered actuator PWM.
REQ-008 Duty_atual  output  8  duty value currently applied to PWM_out.
REQ-009 Nova_amostra  output  1  one-cycle pulse: a pending sample was consumed at a period boundary.
REQ-010 Saturado  output  1  high while the last duty update was slew-limited.

Function
REQ-011 Capture: Amostra_en=1 SHALL load Saida_defuzzy into target register Alvo and set flag Pendente on the same edge.
REQ-012 Multiple strobes within one PWM period: last one wins; earlier values are discarded silently.
REQ-013 Prescaler: counter Pre counts 0..PRESCALER-1 and wraps; Tick=1 when Pre==PRESCALER-1 (PRESCALER=1 gives Tick every cycle).
REQ-014 PWM counter Cnt (8-bit) increments on Tick and wraps 255->0; PWM period = 256*PRESCALER clk_0 cycles.
REQ-015 Boundary event B = Tick AND Cnt==255; duty updates only at B, never mid-period.
REQ-016 At B: diff = Alvo - Duty_atual, 9-bit signed arithmetic; |diff|<=PASSO_MAX -> Duty_atual<=Alvo, Saturado<=0; diff>PASSO_MAX -> Duty_atual+PASSO_MAX, Saturado<=1; diff<-PASSO_MAX -> Duty_atual-PASSO_MAX, Saturado<=1.
REQ-017 Duty_atual SHALL stay within 0..255 with no wrap-around; this follows from REQ-016 because Alvo is 0..255.
REQ-018 At B with Pendente=1: Nova_amostra pulses high for exactly the next cycle, and Pendente clears.
REQ-019 At B with Pendente=0: Nova_amostra stays 0. Slew stepping still continues toward Alvo.
REQ-020 Amostra_en coinciding with B: the update uses the Alvo value held before that edge; the new value is captured; Pendente remains 1 for the next boundary.
REQ-021 PWM_out is registered as (Cnt < Duty_atual) and lags Cnt by one cycle.
REQ-022 Duty 0 -> PWM_out constantly 0; duty 255 -> PWM_out high for 255 of 256 count steps per period.
REQ-023 Saturado holds its value between boundaries.

Reset
REQ-024 Srst=0 at a clock edge SHALL clear Pre, Cnt, Alvo, Duty_atual, Pendente, PWM_out, Nova_amostra and Saturado to 0.
REQ-025 Reset mid-period SHALL abort the period; after release, counting restarts at Pre=0, Cnt=0.
REQ-026 Amostra_en is ignored while Srst=0.

Verification
REQ-027 PRESCALER=1, PASSO_MAX=16; after reset, strobe 0x08 -> at first B, Duty_atual=8, Saturado=0, Nova_amostra one pulse; next period PWM_out high for exactly 8 cycles.
REQ-028 PASSO_MAX=16, Duty_atual=0; strobe 0xC8 once -> duty sequence 16,32,...,192,200 over 13 boundaries; Saturado=1 for the first 12 boundaries, 0 at the 13th; exactly one Nova_amostra.
REQ-029 Duty_atual=0xF0; strobe 0x00 -> duty steps down by 16 to 0 with no underflow; Saturado clears at 0.
REQ-030 Three strobes 0x10, 0x40, 0x20 in one period, the last coincident with B -> boundary uses the prior value 0x40; the next boundary applies 0x20 and pulses Nova_amostra again.
REQ-031 PRESCALER=4: PWM period measured as 1024 cycles; duty 0 and duty 255 patterns per REQ-022.
REQ-032 Assert Srst=0 at Cnt=100 with duty 0x80 -> all outputs 0 on the next edge; after release, the first B occurs 256*PRESCALER cycles later.

Source files
------------

// File: rtl/saida_pwm_defuzzy.sv
// rtl/saida_pwm_defuzzy.sv - slew-limited PWM actuator stage fed by the defuzzifier crisp output
module saida_pwm_defuzzy #(
  parameter int PASSO_MAX = 16,
  parameter int PRESCALER = 4
) (
  input  logic       clk_0,
  input  logic       Srst,
  input  logic       Amostra_en,
  input  logic [7:0] Saida_defuzzy,
  output logic       PWM_out,
  output logic [7:0] Duty_atual,
  output logic       Nova_amostra,
  output logic       Saturado
);

  localparam int PW = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;
  localparam logic [PW-1:0]     PRE_LAST = PW'(PRESCALER - 1);
  localparam logic signed [8:0] PASSO_S  = 9'(PASSO_MAX);
  localparam logic [7:0]        PASSO_U  = 8'(PASSO_MAX);

  logic [PW-1:0]     pre;
  logic [7:0]        cnt;
  logic [7:0]        alvo;
  logic              pendente;
  logic              tick;
  logic              fronteira;
  logic signed [8:0] diff;
  logic [7:0]        duty_next;
  logic              sat_next;

  assign tick      = (pre == PRE_LAST);
  assign fronteira = tick && (cnt == 8'hFF);

  // Step toward the target by at most PASSO_MAX; a saturated step can never
  // cross the target, so the result always stays inside 0..255.
  always_comb begin
    diff      = $signed({1'b0, alvo}) - $signed({1'b0, Duty_atual});
    duty_next = alvo;
    sat_next  = 1'b0;
    if (diff > PASSO_S) begin
      duty_next = Duty_atual + PASSO_U;
      sat_next  = 1'b1;
    end else if (diff < -PASSO_S) begin
      duty_next = Duty_atual - PASSO_U;
      sat_next  = 1'b1;
    end
  end

  always_ff @(posedge clk_0) begin
    if (!Srst) begin
      pre          <= '0;
      cnt          <= '0;
      alvo         <= '0;
      pendente     <= 1'b0;
      Duty_atual   <= '0;
      PWM_out      <= 1'b0;
      Nova_amostra <= 1'b0;
      Saturado     <= 1'b0;
    end else begin
      Nova_amostra <= 1'b0;
      pre          <= tick ? '0 : pre + 1'b1;
      if (tick) begin
        cnt <= cnt + 8'd1;
      end
      PWM_out <= (cnt < Duty_atual);
      if (fronteira) begin
        Duty_atual   <= duty_next;
        Saturado     <= sat_next;
        Nova_amostra <= pendente;
        pendente     <= 1'b0;
      end
      // A strobe on the boundary edge wins over the clear so it is applied next period.
      if (Amostra_en) begin
        alvo     <= Saida_defuzzy;
        pendente <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_saida_pwm_defuzzy.sv
// tb/tb_saida_pwm_defuzzy.sv - directed scoreboard bench for saida_pwm_defuzzy
module tb_saida_pwm_defuzzy;

  logic       clk = 1'b0;
  logic       srst;
  logic       en1, en4;
  logic [7:0] d1, d4;
  logic       pwm1, pwm4, nova1, nova4, sat1, sat4;
  logic [7:0] duty1, duty4;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;

  typedef struct {
    logic [7:0] duty;
    logic       sat;
    logic       nova;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  saida_pwm_defuzzy #(.PASSO_MAX(16), .PRESCALER(1)) dut1 (
    .clk_0(clk), .Srst(srst), .Amostra_en(en1), .Saida_defuzzy(d1),
    .PWM_out(pwm1), .Duty_atual(duty1), .Nova_amostra(nova1), .Saturado(sat1)
  );

  saida_pwm_defuzzy #(.PASSO_MAX(255), .PRESCALER(4)) dut4 (
    .clk_0(clk), .Srst(srst), .Amostra_en(en4), .Saida_defuzzy(d4),
    .PWM_out(pwm4), .Duty_atual(duty4), .Nova_amostra(nova4), .Saturado(sat4)
  );

  // Edges since reset release; a boundary edge is every 256*PRESCALER edges.
  always @(posedge clk) begin
    if (!srst) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input int duty, input bit sat, input bit nova);
    exp_t e;
    e.duty = 8'(duty);
    e.sat  = sat;
    e.nova = nova;
    sb.push_back(e);
  endtask

  task automatic compare_pop(input int sel, input string tag);
    exp_t e;
    chk({tag, "_queue"}, 32'(sb.size() > 0), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, "_duty"}, sel ? duty4 : duty1, e.duty);
    chk({tag, "_sat"},  sel ? sat4  : sat1,  e.sat);
    chk({tag, "_nova"}, sel ? nova4 : nova1, e.nova);
  endtask

  task automatic wait_phase(input int per, input int phase);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((cyc % per) != phase && n < per + 2);
  endtask

  task automatic boundary(input int sel, input int per, input string tag);
    wait_phase(per, 0);
    compare_pop(sel, tag);
  endtask

  task automatic strobe(input int sel, input logic [7:0] val);
    if (sel != 0) begin en4 = 1'b1; d4 = val; end
    else          begin en1 = 1'b1; d1 = val; end
    @(negedge clk);
    en1 = 1'b0;
    en4 = 1'b0;
  endtask

  task automatic count_high(input int sel, input int n, output int hi);
    hi = 0;
    repeat (n) begin
      @(negedge clk);
      if ((sel ? pwm4 : pwm1) === 1'b1) hi++;
    end
  endtask

  initial begin
    int hi, h2;
    srst = 1'b0; en1 = 1'b0; en4 = 1'b0; d1 = '0; d4 = '0;
    repeat (3) @(negedge clk);
    chk("rst_pwm", pwm1, 0);
    chk("rst_duty", duty1, 0);
    chk("rst_nova", nova1, 0);
    chk("rst_sat", sat1, 0);
    srst = 1'b1;

    // Small step: applied at first boundary, 8 high cycles next period
    repeat (10) @(negedge clk);
    strobe(0, 8'h08);
    sb_push(8, 0, 1);
    boundary(0, 256, "r27");
    @(negedge clk);
    chk("r27_nova_width", nova1, 0);
    hi = (pwm1 === 1'b1) ? 1 : 0;
    count_high(0, 255, h2);
    chk("r27_high_count", hi + h2, 8);

    // Ramp up 0 -> 200 in 16-LSB slew steps
    strobe(0, 8'h00);
    sb_push(0, 0, 1);
    boundary(0, 256, "r28_zero");
    strobe(0, 8'hC8);
    for (int k = 1; k <= 12; k++) sb_push(16 * k, 1, k == 1);
    sb_push(200, 0, 0);
    for (int k = 0; k < 13; k++) boundary(0, 256, "r28_up");

    // Up to 0xF0, then ramp down to 0 without underflow
    strobe(0, 8'hF0);
    sb_push(216, 1, 1); sb_push(232, 1, 0); sb_push(240, 0, 0);
    for (int k = 0; k < 3; k++) boundary(0, 256, "r29_top");
    strobe(0, 8'h00);
    for (int k = 1; k <= 14; k++) sb_push(240 - 16 * k, 1, k == 1);
    sb_push(0, 0, 0);
    sb_push(0, 0, 0);
    for (int k = 0; k < 16; k++) boundary(0, 256, "r29_down");

    // Three strobes in one period, last one on the boundary edge
    wait_phase(256, 50);
    strobe(0, 8'h10);
    wait_phase(256, 150);
    strobe(0, 8'h40);
    wait_phase(256, 255);
    strobe(0, 8'h20);
    sb_push(16, 1, 1);
    compare_pop(0, "r30_first");
    sb_push(32, 0, 1); sb_push(32, 0, 0);
    for (int k = 0; k < 2; k++) boundary(0, 256, "r30_next");

    // Reach duty 0x80, then reset mid-period at Cnt=100
    strobe(0, 8'h80);
    for (int k = 1; k <= 5; k++) sb_push(32 + 16 * k, 1, k == 1);
    sb_push(128, 0, 0);
    for (int k = 0; k < 6; k++) boundary(0, 256, "r32_ramp");
    wait_phase(256, 100);
    chk("r32_pre_pwm", pwm1, 1);
    srst = 1'b0;
    @(negedge clk);
    chk("r32_rst_pwm", pwm1, 0);
    chk("r32_rst_duty", duty1, 0);
    chk("r32_rst_nova", nova1, 0);
    chk("r32_rst_sat", sat1, 0);
    strobe(0, 8'h77);
    srst = 1'b1;
    sb_push(0, 0, 0);
    boundary(0, 256, "r26_ignored");
    strobe(0, 8'h05);
    wait_phase(256, 255);
    chk("r32_early_duty", duty1, 0);
    chk("r32_early_nova", nova1, 0);
    sb_push(5, 0, 1);
    @(negedge clk);
    compare_pop(0, "r32_b");

    // PRESCALER=4: 1024-cycle period, duty 0 and duty 255 patterns
    srst = 1'b0;
    repeat (2) @(negedge clk);
    srst = 1'b1;
    strobe(1, 8'hFF);
    count_high(1, 1022, hi);
    chk("r31_duty0_high", hi, 0);
    chk("r31_pre_duty", duty4, 0);
    sb_push(255, 0, 1);
    @(negedge clk);
    compare_pop(1, "r31_b1");
    count_high(1, 1024, hi);
    chk("r31_duty255_high", hi, 1020);
    strobe(1, 8'h00);
    wait_phase(1024, 1023);
    chk("r31_late_duty", duty4, 255);
    sb_push(0, 0, 1);
    @(negedge clk);
    compare_pop(1, "r31_b3");
    count_high(1, 1024, hi);
    chk("r31_back0_high", hi, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
